// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter in front of a FIFO write port.
// Optional macro FIFO_ARB_PRIO0_EN: requester 0 wins in IDLE over round-robin,
// but yields for one burst to the other requesters after each of its own bursts.
module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0]   req_data,
  input  logic                            fifo_full,
  input  logic                            fifo_overflow,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              accept,
  output logic                            fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]           fifo_data_in,
  output logic                            busy,
  output logic                            ovf_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BURST_LEN) + 1;
  typedef enum logic [1:0] {IDLE, GRANT, STALL} state_t;
  state_t state, state_nx;
  logic [IW-1:0] g, g_nx, last_gnt, last_nx, win;
  logic [BW-1:0] beat_cnt, beat_nx;
  logic [NUM_REQ-1:0] gnt_nx, rr_req;
  logic found, rel;
`ifdef FIFO_ARB_PRIO0_EN
  logic was0;
  // after a burst of requester 0, the others get one turn if any is waiting
  assign rr_req = (was0 && |req[NUM_REQ-1:1]) ? {req[NUM_REQ-1:1], 1'b0} : req;
`else
  assign rr_req = req;
`endif
  assign fifo_wr_en   = (state == GRANT) && req[g] && !fifo_full;
  assign accept       = fifo_wr_en ? gnt : '0;
  assign fifo_data_in = (|gnt) ? req_data[g*FIFO_WIDTH +: FIFO_WIDTH] : '0;
  assign busy         = state != IDLE;
  assign rel          = (state != IDLE) && (!req[g] || (fifo_wr_en && beat_cnt == BW'(BURST_LEN - 1)));
  // round-robin search starting just after the last released grant
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++)
      if (!found && rr_req[(int'(last_gnt) + k) % NUM_REQ]) begin
        win = IW'((int'(last_gnt) + k) % NUM_REQ);
        found = 1'b1;
      end
`ifdef FIFO_ARB_PRIO0_EN
    if (req[0] && !was0) win = '0;
`endif
  end
  // next-state, grant and burst counter
  always_comb begin
    state_nx = state;
    g_nx = g;
    gnt_nx = gnt;
    beat_nx = beat_cnt;
    last_nx = last_gnt;
    if (state == IDLE && |req) begin
      state_nx = GRANT;
      g_nx = win;
      gnt_nx = '0;
      gnt_nx[win] = 1'b1;
      beat_nx = '0;
    end else if (rel) begin
      state_nx = IDLE;
      gnt_nx = '0;
`ifdef FIFO_ARB_PRIO0_EN
      last_nx = (g == '0) ? last_gnt : g;
`else
      last_nx = g;
`endif
    end else if (state == GRANT && fifo_full) state_nx = STALL;
    else if (state == STALL && !fifo_full) state_nx = GRANT;
    else if (fifo_wr_en) beat_nx = beat_cnt + 1'b1;
  end
  // state registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      g <= '0;
      gnt <= '0;
      beat_cnt <= '0;
      last_gnt <= IW'(NUM_REQ - 1);
    end else begin
      state <= state_nx;
      g <= g_nx;
      gnt <= gnt_nx;
      beat_cnt <= beat_nx;
      last_gnt <= last_nx;
    end
  // sticky overflow flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_err <= 1'b0;
    else if (fifo_overflow) ovf_err <= 1'b1;
`ifdef FIFO_ARB_PRIO0_EN
  // remembers whether the most recent grant went to requester 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) was0 <= 1'b0;
    else if (state == IDLE && |req) was0 <= (win == '0);
`endif
endmodule
